// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one in-order memory port between instruction fetch and the LSU.
// Optional performance counters are compiled in when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                err_orphan_rsp
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_lsu_grants,
    output logic [31:0]         perf_conflict_cycles
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(MAX_OUTST);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

    // Tag FIFO: one src bit (1 = IF) and one drop bit per in-flight request
    logic [MAX_OUTST-1:0] r_tag_src;
    logic [MAX_OUTST-1:0] r_tag_drop;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [SC_W-1:0]      r_starve_cnt;
    logic                 r_force_if;
    logic                 r_err_orphan;

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_if_elig;
    logic            w_sel_if;
    logic            w_sel_lsu;
    logic            w_req_any;
    logic            w_grant;
    logic            w_if_grant;
    logic            w_lsu_grant;
    logic            w_pop;
    logic            w_head_src;
    logic            w_head_drop;
    logic            w_force_clr;
    logic            w_force_nxt;
    logic [SC_W-1:0] w_starve_nxt;

    assign w_fifo_full  = (r_count == CNT_W'(MAX_OUTST));
    assign w_fifo_empty = (r_count == {CNT_W{1'b0}});

    assign w_if_elig   = if_req_valid & ~flush;
    assign w_sel_if    = w_if_elig & (r_force_if | ~lsu_req_valid);
    assign w_sel_lsu   = lsu_req_valid & ~w_sel_if;
    assign w_req_any   = (w_sel_if | w_sel_lsu) & ~w_fifo_full;
    assign w_grant     = w_req_any & mem_req_ready;
    assign w_if_grant  = w_grant & w_sel_if;
    assign w_lsu_grant = w_grant & w_sel_lsu;

    // A flush in the pop cycle must still suppress a wrong-path fetch response
    assign w_pop       = mem_rsp_valid & ~w_fifo_empty;
    assign w_head_src  = r_tag_src[r_rd_ptr];
    assign w_head_drop = r_tag_drop[r_rd_ptr] | (flush & w_head_src);

    assign mem_req_valid  = rst_n & w_req_any;
    assign if_req_ready   = rst_n & w_if_grant;
    assign lsu_req_ready  = rst_n & w_lsu_grant;
    assign if_rsp_valid   = rst_n & w_pop & w_head_src & ~w_head_drop;
    assign lsu_rsp_valid  = rst_n & w_pop & ~w_head_src & ~w_head_drop;
    assign if_rsp_rdata   = mem_rsp_rdata;
    assign lsu_rsp_rdata  = mem_rsp_rdata;
    assign err_orphan_rsp = r_err_orphan;

    // Request field mux; fetches are always full-width reads
    always_comb begin
        mem_req_addr  = lsu_req_addr;
        mem_req_we    = lsu_req_we;
        mem_req_wdata = lsu_req_wdata;
        mem_req_wstrb = lsu_req_wstrb;
        if (w_sel_if) begin
            mem_req_addr  = if_req_addr;
            mem_req_we    = 1'b0;
            mem_req_wdata = {DATA_W{1'b0}};
            mem_req_wstrb = {STRB_W{1'b0}};
        end else begin
            mem_req_addr  = lsu_req_addr;
            mem_req_we    = lsu_req_we;
            mem_req_wdata = lsu_req_wdata;
            mem_req_wstrb = lsu_req_wstrb;
        end
    end

    // Starvation counter and force flag next-state; force rises as the count reaches the limit
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        w_force_nxt  = r_force_if;
        w_force_clr  = w_if_grant | flush | ~if_req_valid;
        if (~if_req_valid | w_if_grant) begin
            w_starve_nxt = {SC_W{1'b0}};
        end else if (r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + SC_W'(1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
        if (w_force_clr) begin
            w_force_nxt = 1'b0;
        end else if (w_starve_nxt == SC_W'(STARVE_LIMIT)) begin
            w_force_nxt = 1'b1;
        end else begin
            w_force_nxt = r_force_if;
        end
    end

    // Tag FIFO, occupancy and sticky orphan-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_src    <= {MAX_OUTST{1'b0}};
            r_tag_drop   <= {MAX_OUTST{1'b0}};
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_err_orphan <= 1'b0;
        end else begin
            if (flush) begin
                r_tag_drop <= r_tag_drop | r_tag_src;
            end
            if (w_grant) begin
                r_tag_src[r_wr_ptr]  <= w_sel_if;
                r_tag_drop[r_wr_ptr] <= 1'b0;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_err_orphan <= r_err_orphan | (mem_rsp_valid & w_fifo_empty);
        end
    end

    // Anti-starvation state for the fetch requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {SC_W{1'b0}};
            r_force_if   <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_force_if   <= w_force_nxt;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_lsu;
    logic [31:0] r_perf_conf;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_if   <= 32'd0;
            r_perf_lsu  <= 32'd0;
            r_perf_conf <= 32'd0;
        end else begin
            if (w_if_grant) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (w_lsu_grant) begin
                r_perf_lsu <= r_perf_lsu + 32'd1;
            end
            if (if_req_valid & lsu_req_valid) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_if_grants       = r_perf_if;
    assign perf_lsu_grants      = r_perf_lsu;
    assign perf_conflict_cycles = r_perf_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-cycle arbitration vectors
// followed by hand-written multi-cycle sequences (starvation, FIFO full, ordering, flush, store, orphan).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_we;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        err_orphan_rsp;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_lsu_grants;
    logic [31:0] perf_conflict_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .err_orphan_rsp(err_orphan_rsp)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_lsu_grants(perf_lsu_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    typedef struct {
        logic        if_v;
        logic        lsu_v;
        logic        fl;
        logic        rdy;
        logic        exp_mv;
        logic        exp_ir;
        logic        exp_lr;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush         = 1'b0;
        if_req_valid  = 1'b0;
        if_req_addr   = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_we    = 1'b0;
        lsu_req_wdata = 32'h0;
        lsu_req_wstrb = 4'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        idle();
        if_req_valid  = 1'b1;
        if_req_addr   = addr;
        mem_req_ready = 1'b1;
        #1;
        chk("if_issue_ready", {31'd0, if_req_ready}, 32'd1);
        chk("if_issue_addr", mem_req_addr, addr);
        @(negedge clk);
    endtask

    task automatic respond(input logic [31:0] rd, input logic exp_if, input logic exp_lsu);
        idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd;
        #1;
        chk("rsp_if_valid", {31'd0, if_rsp_valid}, {31'd0, exp_if});
        chk("rsp_lsu_valid", {31'd0, lsu_rsp_valid}, {31'd0, exp_lsu});
        if (exp_if) chk("rsp_if_rdata", if_rsp_rdata, rd);
        if (exp_lsu) chk("rsp_lsu_rdata", lsu_rsp_rdata, rd);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              if  lsu fl  rdy  mv  ir  lr  addr          we  strb  wdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 4'hF, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 4'hF, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 4'hF, 32'h12345678};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 4'hF, 32'h12345678};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0};

        // Reset: outputs quiet even with every request input active
        rst_n = 1'b0;
        idle();
        if_req_valid  = 1'b1;
        lsu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        #3;
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
        chk("rst_if_rsp", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_lsu_rsp", {31'd0, lsu_rsp_valid}, 32'd0);
        chk("rst_err", {31'd0, err_orphan_rsp}, 32'd0);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle arbitration table; inputs drop before the edge so no state changes
        for (int i = 0; i < 8; i++) begin
            if_req_valid  = vecs[i].if_v;
            if_req_addr   = 32'h100;
            lsu_req_valid = vecs[i].lsu_v;
            lsu_req_addr  = 32'h200;
            lsu_req_we    = 1'b1;
            lsu_req_wstrb = 4'hF;
            lsu_req_wdata = 32'h12345678;
            flush         = vecs[i].fl;
            mem_req_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_mem_valid", i), {31'd0, mem_req_valid}, {31'd0, vecs[i].exp_mv});
            chk($sformatf("vec%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, vecs[i].exp_ir});
            chk($sformatf("vec%0d_lsu_ready", i), {31'd0, lsu_req_ready}, {31'd0, vecs[i].exp_lr});
            if (vecs[i].exp_mv) begin
                chk($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].exp_addr);
                chk($sformatf("vec%0d_we", i), {31'd0, mem_req_we}, {31'd0, vecs[i].exp_we});
                chk($sformatf("vec%0d_strb", i), {28'd0, mem_req_wstrb}, {28'd0, vecs[i].exp_strb});
                chk($sformatf("vec%0d_wdata", i), mem_req_wdata, vecs[i].exp_wdata);
            end
            #1;
            idle();
            @(negedge clk);
        end

        // Starvation: LSU wins 8 cycles, IF the 9th, then the pattern repeats; memory answers each grant next cycle
        for (int c = 1; c <= 18; c++) begin
            idle();
            if_req_valid  = 1'b1;
            if_req_addr   = 32'h100;
            lsu_req_valid = 1'b1;
            lsu_req_addr  = 32'h200;
            mem_req_ready = 1'b1;
            mem_rsp_valid = (c > 1);
            mem_rsp_rdata = 32'(c);
            #1;
            chk($sformatf("starve_c%0d_if_ready", c), {31'd0, if_req_ready}, {31'd0, (c == 9 || c == 18)});
            chk($sformatf("starve_c%0d_lsu_ready", c), {31'd0, lsu_req_ready}, {31'd0, !(c == 9 || c == 18)});
            if (c > 1) begin
                chk($sformatf("starve_c%0d_if_rsp", c), {31'd0, if_rsp_valid}, {31'd0, (c == 10)});
                chk($sformatf("starve_c%0d_lsu_rsp", c), {31'd0, lsu_rsp_valid}, {31'd0, (c != 10)});
            end
            if (c == 10) chk("starve_if_rdata", if_rsp_rdata, 32'd10);
            @(negedge clk);
`ifdef MEM_ARB_PERF_EN
            if (c == 9) begin
                chk("perf_lsu_grants", perf_lsu_grants, 32'd8);
                chk("perf_if_grants", perf_if_grants, 32'd1);
                chk("perf_conflict", perf_conflict_cycles, 32'd9);
            end
`endif
        end
        respond(32'h77, 1'b1, 1'b0);

        // FIFO full: 4 loads accepted, 5th blocked, pop does not bypass, grant resumes next cycle
        for (int c = 1; c <= 7; c++) begin
            idle();
            lsu_req_valid = 1'b1;
            lsu_req_addr  = 32'h400 + 32'(c * 4);
            mem_req_ready = 1'b1;
            mem_rsp_valid = (c == 6);
            #1;
            chk($sformatf("full_c%0d_lsu_ready", c), {31'd0, lsu_req_ready}, {31'd0, (c <= 4 || c == 7)});
            chk($sformatf("full_c%0d_mem_valid", c), {31'd0, mem_req_valid}, {31'd0, (c <= 4 || c == 7)});
            if (c == 6) chk("full_pop_lsu_rsp", {31'd0, lsu_rsp_valid}, 32'd1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            respond(32'h500 + 32'(k), 1'b0, 1'b1);
        end

        // In-order routing: IF, LSU load, IF
        issue_if(32'h100);
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h200;
        mem_req_ready = 1'b1;
        #1;
        chk("order_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        chk("order_lsu_addr", mem_req_addr, 32'h200);
        @(negedge clk);
        issue_if(32'h104);
        respond(32'hAAAA0001, 1'b1, 1'b0);
        respond(32'hBBBB0002, 1'b0, 1'b1);
        respond(32'hCCCC0003, 1'b1, 1'b0);

        // Flush drops resident fetch responses, including one popping in the flush cycle
        issue_if(32'h180);
        issue_if(32'h184);
        idle();
        flush = 1'b1;
        #1;
        chk("flush_no_rsp", {31'd0, if_rsp_valid}, 32'd0);
        @(negedge clk);
        respond(32'h1111, 1'b0, 1'b0);
        respond(32'h2222, 1'b0, 1'b0);
        issue_if(32'h188);
        idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h3333;
        flush         = 1'b1;
        #1;
        chk("flush_same_cycle_if_rsp", {31'd0, if_rsp_valid}, 32'd0);
        @(negedge clk);
        issue_if(32'h300);
        respond(32'h300DA7A, 1'b1, 1'b0);

        // Store request fields and its acknowledgement
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h208;
        lsu_req_we    = 1'b1;
        lsu_req_wstrb = 4'b0011;
        lsu_req_wdata = 32'hDEADBEEF;
        mem_req_ready = 1'b1;
        #1;
        chk("store_ready", {31'd0, lsu_req_ready}, 32'd1);
        chk("store_addr", mem_req_addr, 32'h208);
        chk("store_we", {31'd0, mem_req_we}, 32'd1);
        chk("store_wstrb", {28'd0, mem_req_wstrb}, 32'h3);
        chk("store_wdata", mem_req_wdata, 32'hDEADBEEF);
        @(negedge clk);
        respond(32'h0, 1'b0, 1'b1);

        // Orphan response: sticky until reset; reset mid-flight discards tags
        chk("orphan_pre", {31'd0, err_orphan_rsp}, 32'd0);
        respond(32'h9999, 1'b0, 1'b0);
        chk("orphan_set", {31'd0, err_orphan_rsp}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("orphan_sticky", {31'd0, err_orphan_rsp}, 32'd1);
        issue_if(32'h500);
        idle();
        rst_n = 1'b0;
        #1;
        chk("orphan_cleared_by_reset", {31'd0, err_orphan_rsp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        respond(32'h5555, 1'b0, 1'b0);
        chk("orphan_after_reset", {31'd0, err_orphan_rsp}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
